iob_dma_mc_ctrl: RTL and testbench



---
 rtl/iob_dma_pkg.sv | 27 ++
 rtl/iob_dma_mc_ctrl_rr_arbiter.sv | 27 ++
 rtl/iob_reg_e.sv | 33 +++
 rtl/iob_dma_mc_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_iob_dma_mc_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_dma_pkg.sv
// Shared types for the multi-channel DMA scheduler: FSM encoding,
// direction constants and the engine command record.
package iob_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    localparam logic DIR_S2M = 1'b1;
    localparam logic DIR_M2S = 1'b0;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_LEN_W  = 16;
    localparam int CMD_CH_W   = 2;

    // Field order matches the concatenation {dir, addr, len, ch} seen on cmd_*.
    typedef struct packed {
        logic                  dir;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_LEN_W-1:0]  len;
        logic [CMD_CH_W-1:0]   ch;
    } dma_cmd_t;

endpackage

// File: rtl/iob_dma_mc_ctrl_rr_arbiter.sv
// Round-robin pick: first requester after last_i, wrapping modulo N_CH.
// last_i is owned by the parent so it only advances when a transfer retires.
module iob_dma_rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] last_i,
    output logic [CH_W-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    always_comb begin
        logic [CH_W-1:0] idx;
        idx         = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = CH_W'((int'(last_i) + i) % N_CH);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/iob_reg_e.sv
// Enabled register with clock enable and synchronous active-high reset.
module iob_reg_e #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = en_i ? data_i : data_q;
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                data_q <= RST_VAL;
            end else begin
                data_q <= data_d;
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/iob_dma_mc_ctrl.sv
// Multi-channel DMA scheduler: round-robin grant, one engine command at a time,
// stream routing for the granted channel and sticky done/irq reporting.
// Optional watchdog enabled by defining IOB_DMA_MC_TIMEOUT_EN.
module iob_dma_mc_ctrl
    import iob_dma_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       cke_i,
    input  logic                       rst_i,
    input  logic [N_CH-1:0]            ch_start_i,
    input  logic [N_CH-1:0]            ch_dir_i,
    input  logic [N_CH*ADDR_W-1:0]     ch_addr_i,
    input  logic [N_CH*LEN_W-1:0]      ch_len_i,
    input  logic [N_CH-1:0]            ch_clr_i,
    output logic [N_CH-1:0]            ch_busy_o,
    output logic [N_CH-1:0]            ch_done_o,
    output logic [N_CH-1:0]            ch_err_o,
    output logic                       irq_o,
    output logic                       cmd_valid_o,
    input  logic                       cmd_ready_i,
    output logic                       cmd_dir_o,
    output logic [ADDR_W-1:0]          cmd_addr_o,
    output logic [LEN_W-1:0]           cmd_len_o,
    output logic [$clog2(N_CH)-1:0]    cmd_ch_o,
    input  logic [N_CH*DATA_W-1:0]     in_tdata_i,
    input  logic [N_CH-1:0]            in_tvalid_i,
    output logic [N_CH-1:0]            in_tready_o,
    output logic [DATA_W-1:0]          eng_in_tdata_o,
    output logic                       eng_in_tvalid_o,
    input  logic                       eng_in_tready_i,
    input  logic [DATA_W-1:0]          eng_out_tdata_i,
    input  logic                       eng_out_tvalid_i,
    output logic                       eng_out_tready_o,
    output logic [N_CH*DATA_W-1:0]     out_tdata_o,
    output logic [N_CH-1:0]            out_tvalid_o,
    input  logic [N_CH-1:0]            out_tready_i,
    output logic [1:0]                 dbg_state_o
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int SLOT_W = 1 + ADDR_W + LEN_W;

    // Handshakes: cmd_* and every AXI-stream port transfer on a cycle where
    // valid && ready; a valid, once raised, holds with stable payload until taken.

    dma_state_e        state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   done_q, done_d;

    logic [N_CH-1:0]   start_acc;
    logic              dir_a      [N_CH];
    logic [ADDR_W-1:0] addr_a     [N_CH];
    logic [LEN_W-1:0]  len_a      [N_CH];
    logic [DATA_W-1:0] in_data_a  [N_CH];
    logic [DATA_W-1:0] out_data_a [N_CH];

    logic [CH_W-1:0]   arb_idx;
    logic              arb_valid;
    logic              xfer_open;
    logic              beat;

    assign start_acc = ch_start_i & ~pending_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [SLOT_W-1:0] slot;

        iob_reg_e #(.DATA_W(SLOT_W)) u_slot (
            .clk_i  (clk_i),
            .cke_i  (cke_i),
            .rst_i  (rst_i),
            .en_i   (start_acc[k]),
            .data_i ({ch_dir_i[k], ch_addr_i[k*ADDR_W +: ADDR_W], ch_len_i[k*LEN_W +: LEN_W]}),
            .data_o (slot)
        );

        assign dir_a[k]  = slot[SLOT_W-1];
        assign addr_a[k] = slot[LEN_W +: ADDR_W];
        assign len_a[k]  = slot[LEN_W-1:0];

        assign in_data_a[k]                   = in_tdata_i[k*DATA_W +: DATA_W];
        assign out_tdata_o[k*DATA_W +: DATA_W] = out_data_a[k];
    end

    iob_dma_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i       (pending_q),
        .last_i      (last_grant_q),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    // Stream closes itself once the counted length is reached, so a
    // producer that keeps tvalid high never slips an extra beat through.
    assign xfer_open = (state_q == ST_XFER) && (beat_cnt_q < len_a[gnt_q]);

    always_comb begin
        in_tready_o      = '0;
        out_tvalid_o     = '0;
        eng_in_tdata_o   = '0;
        eng_in_tvalid_o  = 1'b0;
        eng_out_tready_o = 1'b0;
        beat             = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            out_data_a[k] = '0;
        end
        if (xfer_open) begin
            if (dir_a[gnt_q] == DIR_S2M) begin
                eng_in_tvalid_o    = in_tvalid_i[gnt_q];
                eng_in_tdata_o     = in_data_a[gnt_q];
                in_tready_o[gnt_q] = eng_in_tready_i;
                beat               = in_tvalid_i[gnt_q] && eng_in_tready_i;
            end else begin
                out_tvalid_o[gnt_q] = eng_out_tvalid_i;
                out_data_a[gnt_q]   = eng_out_tdata_i;
                eng_out_tready_o    = out_tready_i[gnt_q];
                beat                = eng_out_tvalid_i && out_tready_i[gnt_q];
            end
        end
    end

`ifdef IOB_DMA_MC_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic [N_CH-1:0]      err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pending_d    = pending_q | start_acc;
        done_d       = done_q & ~(ch_clr_i | start_acc);
        cmd_valid_o  = 1'b0;
        cmd_dir_o    = 1'b0;
        cmd_addr_o   = '0;
        cmd_len_o    = '0;
        cmd_ch_o     = '0;
`ifdef IOB_DMA_MC_TIMEOUT_EN
        wdog_d       = wdog_q;
        err_d        = err_q & ~(ch_clr_i | start_acc);
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_idx;
                    state_d = (len_a[arb_idx] == '0) ? ST_DONE : ST_CMD;
                end
            end
            ST_CMD: begin
                cmd_valid_o = 1'b1;
                cmd_dir_o   = dir_a[gnt_q];
                cmd_addr_o  = addr_a[gnt_q];
                cmd_len_o   = len_a[gnt_q];
                cmd_ch_o    = gnt_q;
                if (cmd_ready_i) begin
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
`ifdef IOB_DMA_MC_TIMEOUT_EN
                    wdog_d     = '0;
`endif
                end
            end
            ST_XFER: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (beat_cnt_q + LEN_W'(1) == len_a[gnt_q]) begin
                        state_d = ST_DONE;
                    end
                end
`ifdef IOB_DMA_MC_TIMEOUT_EN
                // Stalled transfer is abandoned: error instead of done.
                if (beat) begin
                    wdog_d = '0;
                end else if (wdog_q == TMO_LAST) begin
                    wdog_d           = '0;
                    err_d[gnt_q]     = 1'b1;
                    pending_d[gnt_q] = 1'b0;
                    last_grant_d     = gnt_q;
                    state_d          = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                done_d[gnt_q]    = 1'b1;
                pending_d[gnt_q] = 1'b0;
                last_grant_d     = gnt_q;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q      <= ST_IDLE;
                gnt_q        <= '0;
                last_grant_q <= CH_W'(N_CH - 1);
                beat_cnt_q   <= '0;
                pending_q    <= '0;
                done_q       <= '0;
            end else begin
                state_q      <= state_d;
                gnt_q        <= gnt_d;
                last_grant_q <= last_grant_d;
                beat_cnt_q   <= beat_cnt_d;
                pending_q    <= pending_d;
                done_q       <= done_d;
            end
        end
    end

`ifdef IOB_DMA_MC_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                wdog_q <= '0;
                err_q  <= '0;
            end else begin
                wdog_q <= wdog_d;
                err_q  <= err_d;
            end
        end
    end

    assign ch_err_o = err_q;
`else
    assign ch_err_o = '0;
`endif

    assign ch_busy_o   = pending_q;
    assign ch_done_o   = done_q;
    assign irq_o       = (|done_q) | (|ch_err_o);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_dma_mc_ctrl.sv
// Directed bench for iob_dma_mc_ctrl (4 channels); the watchdog scenario
// runs only when IOB_DMA_MC_TIMEOUT_EN is defined.
module tb_iob_dma_mc_ctrl;
    import iob_dma_pkg::*;

    logic         clk;
    logic         cke_i;
    logic         rst_i;
    logic [3:0]   ch_start_i;
    logic [3:0]   ch_dir_i;
    logic [127:0] ch_addr_i;
    logic [63:0]  ch_len_i;
    logic [3:0]   ch_clr_i;
    logic [3:0]   ch_busy_o;
    logic [3:0]   ch_done_o;
    logic [3:0]   ch_err_o;
    logic         irq_o;
    logic         cmd_valid_o;
    logic         cmd_ready_i;
    logic         cmd_dir_o;
    logic [31:0]  cmd_addr_o;
    logic [15:0]  cmd_len_o;
    logic [1:0]   cmd_ch_o;
    logic [127:0] in_tdata_i;
    logic [3:0]   in_tvalid_i;
    logic [3:0]   in_tready_o;
    logic [31:0]  eng_in_tdata_o;
    logic         eng_in_tvalid_o;
    logic         eng_in_tready_i;
    logic [31:0]  eng_out_tdata_i;
    logic         eng_out_tvalid_i;
    logic         eng_out_tready_o;
    logic [127:0] out_tdata_o;
    logic [3:0]   out_tvalid_o;
    logic [3:0]   out_tready_i;
    logic [1:0]   dbg_state_o;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    iob_dma_mc_ctrl #(
        .N_CH(4), .ADDR_W(32), .LEN_W(16), .DATA_W(32), .TIMEOUT_W(4)
    ) dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
        .ch_start_i(ch_start_i), .ch_dir_i(ch_dir_i), .ch_addr_i(ch_addr_i),
        .ch_len_i(ch_len_i), .ch_clr_i(ch_clr_i),
        .ch_busy_o(ch_busy_o), .ch_done_o(ch_done_o), .ch_err_o(ch_err_o), .irq_o(irq_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_dir_o(cmd_dir_o),
        .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o), .cmd_ch_o(cmd_ch_o),
        .in_tdata_i(in_tdata_i), .in_tvalid_i(in_tvalid_i), .in_tready_o(in_tready_o),
        .eng_in_tdata_o(eng_in_tdata_o), .eng_in_tvalid_o(eng_in_tvalid_o),
        .eng_in_tready_i(eng_in_tready_i),
        .eng_out_tdata_i(eng_out_tdata_i), .eng_out_tvalid_i(eng_out_tvalid_i),
        .eng_out_tready_o(eng_out_tready_o),
        .out_tdata_o(out_tdata_o), .out_tvalid_o(out_tvalid_o), .out_tready_i(out_tready_i),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Driver tasks
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic d, input logic [31:0] a, input logic [15:0] l);
        ch_dir_i[k]          = d;
        ch_addr_i[k*32 +: 32] = a;
        ch_len_i[k*16 +: 16]  = l;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic clr_all();
        ch_clr_i = 4'hF;
        cyc();
        ch_clr_i = 4'h0;
    endtask

    task automatic wait_done(input int k, input string tag);
        for (int c = 0; c < 60 && !ch_done_o[k]; c++) cyc();
        #1;
        chk(tag, ch_done_o[k], 1'b1);
    endtask

    dma_cmd_t exp_cmd;
    int       beats;
    bit       restarted;

    initial begin
        cke_i = 1'b1; rst_i = 1'b1;
        ch_start_i = '0; ch_dir_i = '0; ch_addr_i = '0; ch_len_i = '0; ch_clr_i = '0;
        cmd_ready_i = 1'b1;
        in_tdata_i = '0; in_tvalid_i = '0; eng_in_tready_i = 1'b0;
        eng_out_tdata_i = '0; eng_out_tvalid_i = 1'b0; out_tready_i = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_busy", ch_busy_o, 4'h0);
        chk("rst_done", ch_done_o, 4'h0);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_cmd_valid", cmd_valid_o, 1'b0);
        chk("rst_state", dbg_state_o, 2'd0);
        rst_i = 1'b0;
        cyc();

        // Single channel: ch2, stream->mem, len 4, addr 0x100
        set_ch(2, 1'b1, 32'h100, 16'd4);
        ch_start_i = 4'b0100;
        cyc();
        ch_start_i = '0; #1;
        chk("t1_busy", ch_busy_o, 4'b0100);
        chk("t1_no_cmd_yet", cmd_valid_o, 1'b0);
        cyc(); #1;
        chk("t1_cmd_valid", cmd_valid_o, 1'b1);
        exp_cmd = '{dir: 1'b1, addr: 32'h100, len: 16'd4, ch: 2'd2};
        chk("t1_cmd_fields", {cmd_dir_o, cmd_addr_o, cmd_len_o, cmd_ch_o}, exp_cmd);
        in_tvalid_i[2] = 1'b1; eng_in_tready_i = 1'b1; in_tdata_i[95:64] = 32'hD000_0000; #1;
        chk("t1_closed_in_cmd", in_tready_o, 4'h0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            in_tdata_i[95:64] = 32'hD000_0000 + i; #1;
            chk("t1_eng_valid", eng_in_tvalid_o, 1'b1);
            chk("t1_eng_data", eng_in_tdata_o, 32'hD000_0000 + i);
            chk("t1_ready_route", in_tready_o, 4'b0100);
            cyc();
        end
        #1;
        chk("t1_fifth_blocked", in_tready_o, 4'h0);
        chk("t1_done_not_yet", ch_done_o, 4'h0);
        cyc(); #1;
        chk("t1_done", ch_done_o, 4'b0100);
        chk("t1_irq", irq_o, 1'b1);
        chk("t1_busy_clear", ch_busy_o, 4'h0);
        in_tvalid_i = '0;
        clr_all(); #1;
        chk("t1_clr_done", ch_done_o, 4'h0);
        chk("t1_clr_irq", irq_o, 1'b0);

        // Round-robin: 0,1,3 together, then 0 re-requested during 1 -> 0,1,3,0
        do_reset();
        for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 32'h1000 * (k + 1), 16'd2);
        in_tvalid_i = 4'hF; eng_in_tready_i = 1'b1;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        restarted = 1'b0;
        ch_start_i = 4'b1011;
        for (int c = 0; c < 80 && !(exp_q.size() == 0 && ch_busy_o == 4'h0); c++) begin
            #1;
            if (cmd_valid_o && exp_q.size() > 0) begin
                chk("rr_order", cmd_ch_o, exp_q.pop_front());
                if (cmd_ch_o == 2'd1 && !restarted) begin
                    ch_start_i = 4'b0001;
                    restarted  = 1'b1;
                end
            end
            chk("rr_single_route", $countones(in_tready_o) <= 1, 1'b1);
            cyc();
            ch_start_i = '0;
        end
        chk("rr_all_issued", exp_q.size(), 0);
        chk("rr_idle_after", ch_busy_o, 4'h0);
        in_tvalid_i = '0;
        clr_all();

        // Backpressure: ch1, mem->stream, len 3, out_tready toggling
        set_ch(1, 1'b0, 32'h200, 16'd3);
        eng_out_tvalid_i = 1'b1; out_tready_i = '0; beats = 0;
        ch_start_i = 4'b0010;
        cyc();
        ch_start_i = '0;
        for (int c = 0; c < 40 && !ch_done_o[1]; c++) begin
            out_tready_i[1] = ~out_tready_i[1];
            eng_out_tdata_i = 32'hA000_0000 + c; #1;
            if (out_tvalid_o[1]) chk("bp_data", out_tdata_o[63:32], eng_out_tdata_i);
            chk("bp_others_quiet", out_tvalid_o & 4'b1101, 4'h0);
            if (out_tvalid_o[1] && out_tready_i[1]) begin
                chk("bp_eng_ready", eng_out_tready_o, 1'b1);
                beats++;
            end
            cyc();
        end
        #1;
        chk("bp_beats", beats, 3);
        chk("bp_done", ch_done_o, 4'b0010);
        eng_out_tvalid_i = 1'b0; out_tready_i = '0;
        clr_all();

        // Zero length: no command; IDLE grant, DONE state, then done visible
        set_ch(3, 1'b1, 32'h300, 16'd0);
        ch_start_i = 4'b1000;
        cyc();
        ch_start_i = '0; #1;
        chk("z_busy", ch_busy_o, 4'b1000);
        chk("z_no_cmd_a", cmd_valid_o, 1'b0);
        cyc(); #1;
        chk("z_no_cmd_b", cmd_valid_o, 1'b0);
        chk("z_done_state", dbg_state_o, 2'd3);
        chk("z_done_not_yet", ch_done_o, 4'h0);
        cyc(); #1;
        chk("z_done", ch_done_o, 4'b1000);
        chk("z_idle", ch_busy_o, 4'h0);
        clr_all();

        // Start while busy is ignored: latched len/addr stay from first start
        set_ch(0, 1'b1, 32'h400, 16'd2);
        ch_start_i = 4'b0001;
        cyc();
        set_ch(0, 1'b0, 32'h999, 16'd7);
        cyc();
        ch_start_i = '0; #1;
        exp_cmd = '{dir: 1'b1, addr: 32'h400, len: 16'd2, ch: 2'd0};
        chk("busy_ign_cmd", {cmd_valid_o, cmd_dir_o, cmd_addr_o, cmd_len_o, cmd_ch_o}, {1'b1, exp_cmd});
        in_tvalid_i = 4'b0001; eng_in_tready_i = 1'b1;
        wait_done(0, "busy_ign_done");
        in_tvalid_i = '0;
        clr_all();

        // Reset mid-transfer: ch1 len 8, reset after 2 beats
        set_ch(1, 1'b1, 32'h500, 16'd8);
        ch_start_i = 4'b0010;
        cyc();
        ch_start_i = '0;
        cyc();
        in_tvalid_i = 4'b0010;
        cyc(); cyc(); cyc();
        in_tvalid_i = '0;
        rst_i = 1'b1;
        cyc(); #1;
        chk("rmid_busy", ch_busy_o, 4'h0);
        chk("rmid_done", ch_done_o, 4'h0);
        chk("rmid_irq", irq_o, 1'b0);
        chk("rmid_cmd", cmd_valid_o, 1'b0);
        chk("rmid_streams", {in_tready_o, eng_in_tvalid_o, out_tvalid_o}, 9'h0);
        rst_i = 1'b0;
        set_ch(1, 1'b1, 32'h500, 16'd8);
        ch_start_i = 4'b0010;
        cyc();
        ch_start_i = '0; in_tvalid_i = 4'b0010; beats = 0;
        for (int c = 0; c < 60 && !ch_done_o[1]; c++) begin
            #1;
            if (in_tvalid_i[1] && in_tready_o[1]) beats++;
            cyc();
        end
        #1;
        chk("rmid_restart_done", ch_done_o, 4'b0010);
        chk("rmid_restart_beats", beats, 8);
        in_tvalid_i = '0;
        clr_all();

`ifdef IOB_DMA_MC_TIMEOUT_EN
        // Watchdog: last grant was 1, so ch2 goes first, stalls, errors; ch0 follows
        set_ch(0, 1'b1, 32'h600, 16'd2);
        set_ch(2, 1'b1, 32'h700, 16'd2);
        ch_start_i = 4'b0101;
        cyc();
        ch_start_i = '0;
        cyc(); #1;
        chk("tmo_first_cmd", cmd_ch_o, 2'd2);
        for (int c = 0; c < 40 && !ch_err_o[2]; c++) cyc();
        #1;
        chk("tmo_err", ch_err_o, 4'b0100);
        chk("tmo_no_done", ch_done_o, 4'h0);
        chk("tmo_irq", irq_o, 1'b1);
        for (int c = 0; c < 10 && !cmd_valid_o; c++) begin
            cyc(); #1;
        end
        chk("tmo_next_grant", {cmd_valid_o, cmd_ch_o}, {1'b1, 2'd0});
`else
        chk("err_tied_low", ch_err_o, 4'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
